arb_mux_n: RTL
==============

# arb_mux_n

Parametrised N-channel, W-bit arbitrated multiplexer with a registered output stage and valid/ready handshakes on every channel. It is the sequential successor to the datapath's fixed 2/3-input selectors. It merges several requesters into one consumer, for example the writeback-result and memory-request paths, granting at most one channel per cycle under round-robin or fixed-priority policy and holding the result until the consumer accepts it.

## Interface
- N, default 4: number of input channels, 1..16.
- W, default 32: data width in bits, ≥1.
- MODE, default ARB_RR: arbitration policy. ARB_RR is round-robin. ARB_FIXED gives the lowest index the highest priority.
- SELW, derived: max(1, clog2(N)), width of the channel index.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  N  per-channel request; bit i belongs to channel i.
- in_data  in  N*W  channel i data at bits [i*W +: W].
- in_ready  out  N  per-channel accept; at most one bit set; combinational.
- out_valid  out  1  output register holds a beat.
- out_data  out  W  registered data of the held beat.
- out_sel  out  SELW  index of the channel that supplied the held beat.
- out_ready  in  1  consumer accepts the beat.

## Operation
- Output stage FSM has two states.
  - EMPTY: out_valid=0.
  - FULL: out_valid=1.
- Define can_load = !out_valid || out_ready.
- Grant: if can_load and any in_valid bit is set, exactly one channel g is granted, with in_ready[g]=1. All other in_ready bits are 0. If can_load=0, in_ready is all zero.
- A transfer on channel g occurs when in_valid[g] && in_ready[g]. On that edge out_data←in_data[g], out_sel←g and out_valid←1.
- Transitions:
  - EMPTY→FULL on a transfer.
  - FULL→FULL when out_ready=1 and a transfer occurs in the same cycle (back-to-back).
  - FULL→EMPTY when out_ready=1 and there is no transfer.
  - FULL holds when out_ready=0. out_data and out_sel must not change while FULL && !out_ready.
- ARB_RR policy:
  - A pointer ptr (SELW bits) names the highest-priority channel. Search order is ptr, ptr+1, … mod N.
  - After each transfer on g, ptr←(g+1) mod N. Wrap-around: g=N-1 gives ptr=0.
  - ptr is unchanged when no transfer occurs.
- ARB_FIXED policy: the lowest set index of in_valid wins. ptr is unused and constant 0.
- N=1: the channel is always granted when can_load. out_sel is constant 0.
- in_valid may drop without a grant (no stickiness required). A granted channel's beat is consumed in the same cycle.

## Timing
- Reset (rst_n=0, asynchronous): out_valid=0, out_data=0, out_sel=0, ptr=0, in_ready=0. Reset asserted mid-operation discards any held beat immediately.
- After rst_n deasserts, the first transfer may occur on the first rising edge.
- Latency is 1 cycle from transfer edge to out_valid=1.
- Throughput is one beat per cycle with out_ready held at 1.
- in_ready depends combinationally on in_valid, out_valid and out_ready. out_* is purely registered.
- Simultaneous out_ready=1 and a new transfer loads the new beat with no bubble.

## Structure
- Shared package arb_pkg:
  - ARB_RR=0 and ARB_FIXED=1 constants.
  - A sel_width(N) function returning max(1, clog2(N)).
- One sub-module, rr_arbiter (params N, MODE; ports clk, rst_n, req[N], advance, grant[N] one-hot, grant_idx). It owns ptr and the priority search.
- arb_mux_n holds the output register and FSM, and ANDs grant with can_load.

## Test plan
- Reset/idle: assert rst_n=0 mid-stream with FULL, out_data=0xDEADBEEF. out_valid, out_data and out_sel must be 0 immediately, without waiting for an edge. After release with in_valid=0, out_valid stays 0.
- Single channel, MODE=RR, N=4: in_valid=4'b0100, data2=0x12345678, out_ready=1. in_ready=4'b0100. Next cycle out_valid=1, out_data=0x12345678, out_sel=2, ptr=3.
- Round-robin fairness: in_valid=4'b1111 held and out_ready=1 for 8 cycles. out_sel sequence must be 0,1,2,3,0,1,2,3 (wrap 3→0), one beat per cycle with no bubbles.
- Fixed priority: MODE=ARB_FIXED, in_valid=4'b1010 held for 3 cycles. out_sel=1 every cycle. Channel 3 is never granted while channel 1 requests.
- Backpressure: FULL with out_sel=0, out_data=0xA; out_ready=0 for 3 cycles while in_valid=4'b0010. in_ready must be 0 and out_data stays 0xA. On out_ready=1, channel 1 loads the same cycle and the next out_data equals channel 1 data.
- N=1, W=8 build: in_valid=1, data=0x5A, out_ready toggles 1,0,1. The first beat loads, holds for the stall cycle, then reloads. out_sel=0 throughout.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared arbitration constants, output-stage state encoding and channel-index width helper.
// Pure declarations: no latency, no flow control.
package arb_pkg;

  localparam int ARB_RR    = 0;
  localparam int ARB_FIXED = 1;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } ostate_t;

  function automatic int sel_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// One-hot grant over N requesters, round-robin from ptr or fixed lowest-index priority; grant is combinational.
// ptr moves past the winner only on advance, so an unconsumed grant never changes the rotation.
module rr_arbiter
  import arb_pkg::*;
#(
  parameter int N    = 4,
  parameter int MODE = ARB_RR,
  localparam int SELW = sel_width(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req,
  input  logic            advance,
  output logic [N-1:0]    grant,
  output logic [SELW-1:0] grant_idx
);

  logic [SELW-1:0] ptr;
  logic            found;
  int              idx;

  // In fixed mode ptr never leaves 0, so the same search yields lowest-index priority.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = SELW'(idx);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (advance && MODE == ARB_RR) begin
      if (int'(grant_idx) == N - 1) ptr <= '0;
      else                          ptr <= grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/arb_mux_n.sv
// N-channel arbitrated mux with a one-beat registered output; 1 cycle from transfer edge to out_valid.
// Backpressure: in_ready is all-zero while a held beat is stalled; a drain and a new load share one cycle.
module arb_mux_n
  import arb_pkg::*;
#(
  parameter int N    = 4,
  parameter int W    = 32,
  parameter int MODE = ARB_RR,
  localparam int SELW = sel_width(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    in_valid,
  input  logic [N*W-1:0]  in_data,
  output logic [N-1:0]    in_ready,
  output logic            out_valid,
  output logic [W-1:0]    out_data,
  output logic [SELW-1:0] out_sel,
  input  logic            out_ready
);

  ostate_t         state, state_nxt;
  logic            can_load;
  logic            xfer;
  logic [N-1:0]    grant;
  logic [SELW-1:0] grant_idx;
  logic [W-1:0]    sel_dat;

  assign out_valid = (state == ST_FULL);
  assign can_load  = (state == ST_EMPTY) || out_ready;
  // rst_n gates the grant so no channel sees a handshake while reset is held.
  assign in_ready  = (can_load && rst_n) ? grant : '0;
  assign xfer      = |(in_valid & in_ready);

  rr_arbiter #(
    .N    (N),
    .MODE (MODE)
  ) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (in_valid),
    .advance   (xfer),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  always_comb begin
    sel_dat = '0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) sel_dat = in_data[i*W +: W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_EMPTY;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_EMPTY: if (xfer) state_nxt = ST_FULL;
      ST_FULL:  if (out_ready && !xfer) state_nxt = ST_EMPTY;
      default:  state_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data <= '0;
      out_sel  <= '0;
    end else if (xfer) begin
      out_data <= sel_dat;
      out_sel  <= grant_idx;
    end
  end

endmodule
